mem_arbiter: RTL and testbench

//  Shares the single-ported instruction/data memory between fetch (IF) and load/store (LS).

---
 rtl/mem_arbiter_pkg.sv | 14 +
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: the data word and the
// owner of the single outstanding memory transaction.
package mem_arbiter_pkg;

   typedef logic [31:0] word_t;

   // OWN_NONE doubles as the IDLE state of the arbiter.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_LS   = 2'd2
   } arb_owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported memory between fetch (IF) and load/store (LS), one transaction
// outstanding. Optional MEM_ARB_ROUND_ROBIN_EN swaps fixed LS priority for alternating winners.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic              if_gnt,
   output logic              if_rvalid,
   output word_t             if_rdata,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [3:0]        ls_be,
   input  logic [ADDR_W-1:0] ls_addr,
   input  word_t             ls_wdata,
   output logic              ls_gnt,
   output logic              ls_rvalid,
   output word_t             ls_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output word_t             mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  word_t             mem_rdata
);

   arb_owner_t state_reg;
   logic       lock_reg;
   logic       lock_ls_reg;
   logic       discard_reg;
   logic       discard_next;
   logic       can_issue;
   logic       prio_ls;
   logic       sel_ls;
   logic       issue_if;
   logic       issue_ls;
   logic       resp_if;
   logic       resp_ls;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic rr_ls_reg;
   assign prio_ls = rr_ls_reg;
`else
   assign prio_ls = 1'b1;
`endif

   always_comb begin
      // A new request may go out while idle, or in the response cycle of the current one.
      can_issue = (state_reg == OWN_NONE) | mem_rvalid;
      // An ungranted request keeps its owner so the mem_* payload cannot change under it.
      sel_ls    = lock_reg ? lock_ls_reg : (ls_req & (~if_req | prio_ls));
      mem_req   = ~reset & can_issue & (lock_reg | if_req | ls_req);
      issue_if  = mem_req & ~sel_ls;
      issue_ls  = mem_req & sel_ls;
      if_gnt    = issue_if & mem_gnt;
      ls_gnt    = issue_ls & mem_gnt;

      resp_if   = ~reset & (state_reg == OWN_IF) & mem_rvalid;
      resp_ls   = ~reset & (state_reg == OWN_LS) & mem_rvalid;
      if_rvalid = resp_if & ~discard_reg & ~if_flush;
      ls_rvalid = resp_ls;
      if_rdata  = mem_rdata;
      ls_rdata  = mem_rdata;

      mem_we    = issue_ls & ls_we;
      mem_be    = issue_ls ? ls_be : 4'h0;
      mem_addr  = issue_ls ? ls_addr : (issue_if ? if_addr : '0);
      mem_wdata = (issue_ls & ls_we) ? ls_wdata : '0;

      // The response that consumes the discard clears it; a flush while a fetch is in flight
      // (or being issued/held this cycle) arms it for the next fetch response.
      discard_next = discard_reg;
      if (resp_if) begin
         discard_next = 1'b0;
      end
      if (if_flush & (((state_reg == OWN_IF) & ~mem_rvalid) | issue_if)) begin
         discard_next = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= OWN_NONE;
         lock_reg    <= 1'b0;
         lock_ls_reg <= 1'b0;
         discard_reg <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         rr_ls_reg   <= 1'b1;
`endif
      end else begin
         if (if_gnt) begin
            state_reg <= OWN_IF;
         end else if (ls_gnt) begin
            state_reg <= OWN_LS;
         end else if (mem_rvalid) begin
            state_reg <= OWN_NONE;
         end
         lock_reg    <= mem_req & ~mem_gnt;
         lock_ls_reg <= issue_ls & ~mem_gnt;
         discard_reg <= discard_next;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         if (ls_gnt) begin
            rr_ls_reg <= 1'b0;
         end else if (if_gnt) begin
            rr_ls_reg <= 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter (default build: fixed LS-over-IF priority).
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int ADDR_W = 12;

   logic              clk = 1'b0;
   logic              reset;
   logic              if_req, if_flush, ls_req, ls_we, mem_gnt, mem_rvalid;
   logic [ADDR_W-1:0] if_addr, ls_addr;
   logic [3:0]        ls_be;
   word_t             ls_wdata, mem_rdata;
   logic              if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_we;
   word_t             if_rdata, ls_rdata, mem_wdata;
   logic [3:0]        mem_be;
   logic [ADDR_W-1:0] mem_addr;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   // flags = {if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req}
   typedef struct {
      string             name;
      logic              rst, ifr, fl, lsr, we, gnt, rv;
      logic [ADDR_W-1:0] ifa, lsa;
      logic [3:0]        be;
      word_t             wd, rd;
      logic [4:0]        e_flags;
      logic [ADDR_W-1:0] e_addr;
      logic              e_we;
      logic [3:0]        e_be;
      word_t             e_wd, e_rd;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string name, input logic rst, input logic ifr, input logic [ADDR_W-1:0] ifa,
                      input logic fl, input logic lsr, input logic we, input logic [3:0] be,
                      input logic [ADDR_W-1:0] lsa, input word_t wd, input logic gnt, input logic rv,
                      input word_t rd, input logic [4:0] e_flags, input logic [ADDR_W-1:0] e_addr,
                      input logic e_we, input logic [3:0] e_be, input word_t e_wd, input word_t e_rd);
      vec_t v;
      v.name = name; v.rst = rst; v.ifr = ifr; v.ifa = ifa; v.fl = fl; v.lsr = lsr; v.we = we;
      v.be = be; v.lsa = lsa; v.wd = wd; v.gnt = gnt; v.rv = rv; v.rd = rd;
      v.e_flags = e_flags; v.e_addr = e_addr; v.e_we = e_we; v.e_be = e_be; v.e_wd = e_wd;
      v.e_rd = e_rd;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic rst, input logic ifr, input logic [ADDR_W-1:0] ifa, input logic fl,
                        input logic lsr, input logic we, input logic [3:0] be,
                        input logic [ADDR_W-1:0] lsa, input word_t wd, input logic gnt,
                        input logic rv, input word_t rd);
      reset = rst; if_req = ifr; if_addr = ifa; if_flush = fl; ls_req = lsr; ls_we = we;
      ls_be = be; ls_addr = lsa; ls_wdata = wd; mem_gnt = gnt; mem_rvalid = rv; mem_rdata = rd;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   initial begin
      logic [4:0] flags;
      word_t      rdat;
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // name     rst ifr ifa     fl lsr we be    lsa     wd            gnt rv rd            flags     addr   we be    wd            rd
      add("rst",   1, 1, 12'h100, 0, 1, 0, 4'hF, 12'h040, 0,            1, 1, 32'h1,        5'b00000, 0,      0, 4'h0, 0,            0);
      add("t1_gnt",0, 1, 12'h100, 0, 0, 0, 4'h0, 0,       0,            1, 0, 0,            5'b10001, 12'h100,0, 4'h0, 0,            0);
      add("t1_rsp",0, 0, 0,       0, 0, 0, 4'h0, 0,       0,            0, 1, 32'h13,       5'b01000, 0,      0, 4'h0, 0,            32'h13);
      add("t1_idl",0, 0, 0,       0, 0, 0, 4'h0, 0,       0,            0, 0, 0,            5'b00000, 0,      0, 4'h0, 0,            0);
      add("t2_ls1",0, 1, 12'h104, 0, 1, 0, 4'hF, 12'h040, 0,            1, 0, 0,            5'b00101, 12'h040,0, 4'hF, 0,            0);
      add("t2_ls2",0, 1, 12'h104, 0, 1, 0, 4'hF, 12'h040, 0,            1, 1, 32'h11111111, 5'b00111, 12'h040,0, 4'hF, 0,            32'h11111111);
      add("t2_ls3",0, 1, 12'h104, 0, 1, 0, 4'hF, 12'h040, 0,            1, 1, 32'h22222222, 5'b00111, 12'h040,0, 4'hF, 0,            32'h22222222);
      add("t2_if", 0, 1, 12'h104, 0, 0, 0, 4'h0, 0,       0,            1, 1, 32'h33333333, 5'b10011, 12'h104,0, 4'h0, 0,            32'h33333333);
      add("t2_ifr",0, 0, 0,       0, 0, 0, 4'h0, 0,       0,            0, 1, 32'h44,       5'b01000, 0,      0, 4'h0, 0,            32'h44);
      add("t3_w0", 0, 0, 0,       0, 1, 1, 4'h3, 12'h080, 32'hDEADBEEF, 0, 0, 0,            5'b00001, 12'h080,1, 4'h3, 32'hDEADBEEF, 0);
      add("t3_w1", 0, 1, 12'h108, 0, 1, 1, 4'h3, 12'h080, 32'hDEADBEEF, 0, 0, 0,            5'b00001, 12'h080,1, 4'h3, 32'hDEADBEEF, 0);
      add("t3_w2", 0, 1, 12'h108, 0, 1, 1, 4'h3, 12'h080, 32'hDEADBEEF, 0, 0, 0,            5'b00001, 12'h080,1, 4'h3, 32'hDEADBEEF, 0);
      add("t3_wg", 0, 1, 12'h108, 0, 1, 1, 4'h3, 12'h080, 32'hDEADBEEF, 1, 0, 0,            5'b00101, 12'h080,1, 4'h3, 32'hDEADBEEF, 0);
      add("t3_if", 0, 1, 12'h108, 0, 0, 0, 4'h0, 0,       0,            1, 1, 0,            5'b10011, 12'h108,0, 4'h0, 0,            0);
      add("t3_ifr",0, 0, 0,       0, 0, 0, 4'h0, 0,       0,            0, 1, 32'h55,       5'b01000, 0,      0, 4'h0, 0,            32'h55);
      add("lk_if", 0, 1, 12'h10C, 0, 0, 0, 4'h0, 0,       0,            0, 0, 0,            5'b00001, 12'h10C,0, 4'h0, 0,            0);
      add("lk_hold",0,1, 12'h10C, 0, 1, 0, 4'hF, 12'h044, 0,            0, 0, 0,            5'b00001, 12'h10C,0, 4'h0, 0,            0);
      add("lk_gnt",0, 1, 12'h10C, 0, 1, 0, 4'hF, 12'h044, 0,            1, 0, 0,            5'b10001, 12'h10C,0, 4'h0, 0,            0);
      add("lk_ls", 0, 0, 0,       0, 1, 0, 4'hF, 12'h044, 0,            1, 1, 32'h66,       5'b01101, 12'h044,0, 4'hF, 0,            32'h66);
      add("lk_lsr",0, 0, 0,       0, 0, 0, 4'h0, 0,       0,            0, 1, 32'h77,       5'b00010, 0,      0, 4'h0, 0,            32'h77);
      add("t4_gnt",0, 1, 12'h200, 0, 0, 0, 4'h0, 0,       0,            1, 0, 0,            5'b10001, 12'h200,0, 4'h0, 0,            0);
      add("t4_fl", 0, 0, 0,       1, 0, 0, 4'h0, 0,       0,            0, 0, 0,            5'b00000, 0,      0, 4'h0, 0,            0);
      add("t4_drp",0, 0, 0,       0, 0, 0, 4'h0, 0,       0,            0, 1, 32'hAAAA5555, 5'b00000, 0,      0, 4'h0, 0,            0);
      add("t4_g2", 0, 1, 12'h300, 0, 0, 0, 4'h0, 0,       0,            1, 0, 0,            5'b10001, 12'h300,0, 4'h0, 0,            0);
      add("t4_r2", 0, 0, 0,       0, 0, 0, 4'h0, 0,       0,            0, 1, 32'h12345678, 5'b01000, 0,      0, 4'h0, 0,            32'h12345678);
      add("sf_gnt",0, 1, 12'h304, 0, 0, 0, 4'h0, 0,       0,            1, 0, 0,            5'b10001, 12'h304,0, 4'h0, 0,            0);
      add("sf_drp",0, 0, 0,       1, 0, 0, 4'h0, 0,       0,            0, 1, 32'h00000BAD, 5'b00000, 0,      0, 4'h0, 0,            0);
      add("sf_g2", 0, 1, 12'h308, 0, 0, 0, 4'h0, 0,       0,            1, 0, 0,            5'b10001, 12'h308,0, 4'h0, 0,            0);
      add("sf_r2", 0, 0, 0,       0, 0, 0, 4'h0, 0,       0,            0, 1, 32'h99,       5'b01000, 0,      0, 4'h0, 0,            32'h99);
      add("if_fl", 0, 0, 0,       1, 0, 0, 4'h0, 0,       0,            0, 0, 0,            5'b00000, 0,      0, 4'h0, 0,            0);
      add("if_g3", 0, 1, 12'h30C, 0, 0, 0, 4'h0, 0,       0,            1, 0, 0,            5'b10001, 12'h30C,0, 4'h0, 0,            0);
      add("if_r3", 0, 0, 0,       0, 0, 0, 4'h0, 0,       0,            0, 1, 32'hAB,       5'b01000, 0,      0, 4'h0, 0,            32'hAB);
      add("t5_gnt",0, 0, 0,       0, 1, 0, 4'hF, 12'h048, 0,            1, 0, 0,            5'b00101, 12'h048,0, 4'hF, 0,            0);
      add("t5_rst",1, 0, 0,       0, 0, 0, 4'h0, 0,       0,            0, 0, 0,            5'b00000, 0,      0, 4'h0, 0,            0);
      add("t5_rv", 0, 0, 0,       0, 0, 0, 4'h0, 0,       0,            0, 1, 32'hCC,       5'b00000, 0,      0, 4'h0, 0,            0);
      add("t5_idl",0, 0, 0,       0, 0, 0, 4'h0, 0,       0,            0, 0, 0,            5'b00000, 0,      0, 4'h0, 0,            0);
      add("t6_g0", 0, 1, 12'h400, 0, 0, 0, 4'h0, 0,       0,            1, 0, 0,            5'b10001, 12'h400,0, 4'h0, 0,            0);
      add("t6_g1", 0, 1, 12'h404, 0, 0, 0, 4'h0, 0,       0,            1, 1, 32'h1,        5'b11001, 12'h404,0, 4'h0, 0,            32'h1);
      add("t6_g2", 0, 1, 12'h408, 0, 0, 0, 4'h0, 0,       0,            1, 1, 32'h2,        5'b11001, 12'h408,0, 4'h0, 0,            32'h2);
      add("t6_g3", 0, 1, 12'h40C, 0, 0, 0, 4'h0, 0,       0,            1, 1, 32'h3,        5'b11001, 12'h40C,0, 4'h0, 0,            32'h3);
      add("t6_r3", 0, 0, 0,       0, 0, 0, 4'h0, 0,       0,            0, 1, 32'h4,        5'b01000, 0,      0, 4'h0, 0,            32'h4);

      foreach (vecs[i]) begin
         @(posedge clk);
         #1;
         drive(vecs[i].rst, vecs[i].ifr, vecs[i].ifa, vecs[i].fl, vecs[i].lsr, vecs[i].we,
               vecs[i].be, vecs[i].lsa, vecs[i].wd, vecs[i].gnt, vecs[i].rv, vecs[i].rd);
         @(negedge clk);
         flags = {if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req};
         rdat  = if_rvalid ? if_rdata : (ls_rvalid ? ls_rdata : '0);
         check(vecs[i].name,
               {11'd0, flags, 4'd0, mem_addr, mem_we, mem_be, mem_wdata},
               {11'd0, vecs[i].e_flags, 4'd0, vecs[i].e_addr, vecs[i].e_we, vecs[i].e_be, vecs[i].e_wd});
         $display("vec %-8s flags=%b addr=%h we=%b be=%h wdata=%h rdata=%h",
                  vecs[i].name, flags, mem_addr, mem_we, mem_be, mem_wdata, rdat);
         if (vecs[i].e_flags[3] | vecs[i].e_flags[1]) begin
            check({vecs[i].name, "_rdata"}, {32'd0, rdat}, {32'd0, vecs[i].e_rd});
         end
      end

      // Flush while a fetch is waiting on mem_gnt: request stays up, its response is dropped.
      @(posedge clk); #1;
      drive(0, 1, 12'h500, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("hs_noretract", {62'd0, mem_req, if_gnt}, {62'd0, 2'b10});
      $display("seq flush-pending: mem_req=%b if_gnt=%b addr=%h", mem_req, if_gnt, mem_addr);
      @(posedge clk); #1;
      drive(0, 1, 12'h500, 0, 1, 0, 4'hF, 12'h04C, 0, 1, 0, 0);
      @(negedge clk);
      check("hs_lockgnt", {51'd0, if_gnt, ls_gnt, mem_addr}, {51'd0, 2'b10, 12'h500});
      $display("seq lock-grant: if_gnt=%b ls_gnt=%b addr=%h", if_gnt, ls_gnt, mem_addr);
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 1, 0, 4'hF, 12'h04C, 0, 1, 1, 32'hEE);
      @(negedge clk);
      check("hs_dropped", {61'd0, if_rvalid, ls_gnt, mem_req}, {61'd0, 3'b011});
      $display("seq drop: if_rvalid=%b ls_gnt=%b", if_rvalid, ls_gnt);
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h5A5A);
      @(negedge clk);
      check("hs_lsresp", {32'd0, ls_rvalid, if_rvalid, 30'd0}, {32'd0, 2'b10, 30'd0});
      check("hs_lsdata", {32'd0, ls_rdata}, {32'd0, 32'h5A5A});
      $display("seq ls-resp: ls_rvalid=%b ls_rdata=%h", ls_rvalid, ls_rdata);

      @(posedge clk); #1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
